gyro_frame_assembler: RTL and testbench

Byte-stream-to-register demultiplexer for the PmodGYRO path. It sits between the SPI byte interface and the 4:1 axis output mux. It consumes the 8-byte burst read starting at register 0x26: OUT_TEMP, STATUS, then X, Y and Z, each low byte first. It assembles the bytes into shadow registers and commits complete frames atomically to the x/y/z/temperature outputs that feed the display selection logic.

---
 rtl/gyro_frame_assembler.sv | 125 ++++++++++++
 tb/tb_gyro_frame_assembler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gyro_frame_assembler.sv
// Assembles the 8-byte PmodGYRO burst (TEMP, STATUS, XL..ZH) into shadow registers and commits whole frames atomically.
// Optional: define GYRO_STATUS_GATE_EN to update x/y/z only when STATUS.ZYXDA is set.
module gyro_frame_assembler #(
   parameter int unsigned FRAME_BYTES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_frame,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [15:0] x_axis,
   output logic [15:0] y_axis,
   output logic [15:0] z_axis,
   output logic [7:0]  temp_data,
   output logic [7:0]  status_reg,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_COMMIT
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   state_t     state, state_next;
   logic [2:0] idx, idx_next;
   logic [2:0] wr_idx;
   logic       store;
   logic       commit;
   logic       abort;
   logic [7:0] shadow [FRAME_BYTES];

   always_comb begin
      state_next = state;
      idx_next   = idx;
      wr_idx     = idx;
      store      = 1'b0;
      commit     = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_frame) begin
               state_next = ST_COLLECT;
               idx_next   = '0;
               wr_idx     = '0;
               store      = byte_valid;
               if (byte_valid) idx_next = 3'd1;
            end
         end
         ST_COLLECT: begin
            // A fresh start_frame outranks any in-flight byte, even the last one.
            if (start_frame) begin
               abort    = 1'b1;
               idx_next = '0;
               wr_idx   = '0;
               store    = byte_valid;
               if (byte_valid) idx_next = 3'd1;
            end else if (byte_valid) begin
               store    = 1'b1;
               idx_next = idx + 3'd1;
               if (idx == LAST_IDX) state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            commit     = 1'b1;
            state_next = ST_IDLE;
            idx_next   = '0;
            wr_idx     = '0;
            if (start_frame) begin
               state_next = ST_COLLECT;
               store      = byte_valid;
               if (byte_valid) idx_next = 3'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         x_axis      <= '0;
         y_axis      <= '0;
         z_axis      <= '0;
         temp_data   <= '0;
         status_reg  <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         busy        <= 1'b0;
         for (int unsigned i = 0; i < FRAME_BYTES; i++) shadow[i] <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         frame_done  <= commit;
         frame_abort <= abort;
         busy        <= (state_next == ST_COLLECT);
         if (store) shadow[wr_idx] <= byte_in;
         // Commit reads the old shadow even if a coincident start byte overwrites slot 0.
         if (commit) begin
            temp_data  <= shadow[0];
            status_reg <= shadow[1];
`ifdef GYRO_STATUS_GATE_EN
            if (shadow[1][3]) begin
               x_axis <= {shadow[3], shadow[2]};
               y_axis <= {shadow[5], shadow[4]};
               z_axis <= {shadow[7], shadow[6]};
            end
`else
            x_axis <= {shadow[3], shadow[2]};
            y_axis <= {shadow[5], shadow[4]};
            z_axis <= {shadow[7], shadow[6]};
`endif
         end
      end
   end

endmodule

// File: tb/tb_gyro_frame_assembler.sv
// Directed self-checking bench for gyro_frame_assembler (default build; gate expectations follow GYRO_STATUS_GATE_EN).
module tb_gyro_frame_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_frame;
   logic        byte_valid;
   logic [7:0]  byte_in;
   logic [15:0] x_axis, y_axis, z_axis;
   logic [7:0]  temp_data, status_reg;
   logic        frame_done, frame_abort, busy;

   int unsigned checks = 0;
   int unsigned errors = 0;

   gyro_frame_assembler #(.FRAME_BYTES(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_frame (start_frame),
      .byte_valid  (byte_valid),
      .byte_in     (byte_in),
      .x_axis      (x_axis),
      .y_axis      (y_axis),
      .z_axis      (z_axis),
      .temp_data   (temp_data),
      .status_reg  (status_reg),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sf, input logic bv, input logic [7:0] b);
      start_frame = sf;
      byte_valid  = bv;
      byte_in     = b;
      tick();
      start_frame = 1'b0;
      byte_valid  = 1'b0;
      byte_in     = 8'h00;
   endtask

   task automatic burst(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      drive(1'b1, 1'b1, b0);
      drive(1'b0, 1'b1, b1);
      drive(1'b0, 1'b1, b2);
      drive(1'b0, 1'b1, b3);
      drive(1'b0, 1'b1, b4);
      drive(1'b0, 1'b1, b5);
      drive(1'b0, 1'b1, b6);
      drive(1'b0, 1'b1, b7);
   endtask

   task automatic check_outputs(input string tag, input logic [15:0] x, y, z,
                                input logic [7:0] t, s);
      check({tag, "_x"}, x_axis, x);
      check({tag, "_y"}, y_axis, y);
      check({tag, "_z"}, z_axis, z);
      check({tag, "_temp"}, {8'h00, temp_data}, {8'h00, t});
      check({tag, "_status"}, {8'h00, status_reg}, {8'h00, s});
   endtask

   initial begin
      rst = 1'b1; start_frame = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      tick(); tick();
      rst = 1'b0;
      check_outputs("reset", 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00);
      check("reset_done", {15'd0, frame_done}, 16'd0);
      check("reset_abort", {15'd0, frame_abort}, 16'd0);
      check("reset_busy", {15'd0, busy}, 16'd0);

      // Basic burst
      drive(1'b1, 1'b1, 8'h19);
      check("t1_busy", {15'd0, busy}, 16'd1);
      drive(1'b0, 1'b1, 8'h08); drive(1'b0, 1'b1, 8'h34); drive(1'b0, 1'b1, 8'h12);
      drive(1'b0, 1'b1, 8'h78); drive(1'b0, 1'b1, 8'h56); drive(1'b0, 1'b1, 8'hBC);
      drive(1'b0, 1'b1, 8'h9A);
      check("t1_pre_x", x_axis, 16'h0000);
      check("t1_pre_done", {15'd0, frame_done}, 16'd0);
      tick();
      check_outputs("t1", 16'h1234, 16'h5678, 16'h9ABC, 8'h19, 8'h08);
      check("t1_done", {15'd0, frame_done}, 16'd1);
      tick();
      check("t1_done_off", {15'd0, frame_done}, 16'd0);

      // Abort with partial frame, then full new frame
      drive(1'b1, 1'b1, 8'h11); drive(1'b0, 1'b1, 8'h22); drive(1'b0, 1'b1, 8'h33);
      drive(1'b1, 1'b1, 8'hAA);
      check("t2_abort", {15'd0, frame_abort}, 16'd1);
      check("t2_hold_x", x_axis, 16'h1234);
      drive(1'b0, 1'b1, 8'h08);
      check("t2_abort_off", {15'd0, frame_abort}, 16'd0);
      drive(1'b0, 1'b1, 8'h01); drive(1'b0, 1'b1, 8'h00); drive(1'b0, 1'b1, 8'h02);
      drive(1'b0, 1'b1, 8'h00); drive(1'b0, 1'b1, 8'h03); drive(1'b0, 1'b1, 8'h00);
      check("t2_hold_temp", {8'h00, temp_data}, 16'h0019);
      tick();
      check_outputs("t2", 16'h0001, 16'h0002, 16'h0003, 8'hAA, 8'h08);
      check("t2_done", {15'd0, frame_done}, 16'd1);
      tick();

      // Stray byte in IDLE
      drive(1'b0, 1'b1, 8'hFF);
      check("t3_busy", {15'd0, busy}, 16'd0);
      tick();
      check_outputs("t3", 16'h0001, 16'h0002, 16'h0003, 8'hAA, 8'h08);
      check("t3_done", {15'd0, frame_done}, 16'd0);
      check("t3_abort", {15'd0, frame_abort}, 16'd0);

      // Reset mid-frame after byte 5
      drive(1'b1, 1'b1, 8'h44); drive(1'b0, 1'b1, 8'h08); drive(1'b0, 1'b1, 8'h01);
      drive(1'b0, 1'b1, 8'h02); drive(1'b0, 1'b1, 8'h03); drive(1'b0, 1'b1, 8'h04);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outputs("t4_rst", 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00);
      check("t4_busy", {15'd0, busy}, 16'd0);
      check("t4_abort", {15'd0, frame_abort}, 16'd0);
      burst(8'h55, 8'h08, 8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB);
      tick();
      check_outputs("t4", 16'h4321, 16'h8765, 16'hCBA9, 8'h55, 8'h08);
      tick();

      // ZYXDA gating
      burst(8'h19, 8'h08, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A);
      tick();
      check("t5_pre_x", x_axis, 16'h1234);
      tick();
      burst(8'h66, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33);
      tick();
`ifdef GYRO_STATUS_GATE_EN
      check_outputs("t5", 16'h1234, 16'h5678, 16'h9ABC, 8'h66, 8'h00);
`else
      check_outputs("t5", 16'h1111, 16'h2222, 16'h3333, 8'h66, 8'h00);
`endif
      check("t5_done", {15'd0, frame_done}, 16'd1);
      tick();

      // Start coincident with COMMIT
      burst(8'h10, 8'h08, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFE, 8'hCA);
      drive(1'b1, 1'b1, 8'h77);
      check("t6_done1", {15'd0, frame_done}, 16'd1);
      check("t6_busy", {15'd0, busy}, 16'd1);
      check_outputs("t6a", 16'hBEEF, 16'hDEAD, 16'hCAFE, 8'h10, 8'h08);
      drive(1'b0, 1'b1, 8'h08);
      check("t6_done_off", {15'd0, frame_done}, 16'd0);
      drive(1'b0, 1'b1, 8'h01); drive(1'b0, 1'b1, 8'h02); drive(1'b0, 1'b1, 8'h03);
      drive(1'b0, 1'b1, 8'h04); drive(1'b0, 1'b1, 8'h05); drive(1'b0, 1'b1, 8'h06);
      check("t6_gap", {15'd0, frame_done}, 16'd0);
      tick();
      check("t6_done2", {15'd0, frame_done}, 16'd1);
      check_outputs("t6b", 16'h0201, 16'h0403, 16'h0605, 8'h77, 8'h08);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
